// File: rtl/conv_window_gen.sv
// Streaming K_SIZE x K_SIZE window generator: raster pixels in, one window per valid
// convolution position out (stride 1, no padding) over a valid/ready handshake.
module conv_window_gen #(
    parameter int unsigned K_SIZE = 5,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_pixel,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [15:0] win_out [0:K_SIZE-1][0:K_SIZE-1],
    output logic        win_last,
    output logic        frame_done
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic          frame_done_q;
    logic [15:0]   win_q [0:K_SIZE-1][0:K_SIZE-1];
    // Line i holds row (row - K_SIZE + 1 + i); the last line is the previous row.
    logic [15:0]   lb_q [0:K_SIZE-2][0:IMG_W-1];

    logic accept;
    logic is_emit;
    logic is_last_pix;

    assign in_ready    = !win_valid_q || win_ready;
    assign accept      = in_valid && in_ready;
    assign is_emit     = (col_q >= CW'(K_SIZE - 1)) && (row_q >= RW'(K_SIZE - 1));
    assign is_last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

    assign win_valid  = win_valid_q;
    assign win_last   = win_last_q;
    assign frame_done = frame_done_q;
    assign win_out    = win_q;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        if (win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
        if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Accepts only happen when the held window is free, so a new one may overwrite it.
            if (is_emit) begin
                win_valid_d = 1'b1;
                win_last_d  = is_last_pix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int unsigned i = 0; i < K_SIZE; i++) begin
                for (int unsigned j = 0; j < K_SIZE; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= accept && is_last_pix;
            if (accept) begin
                for (int unsigned i = 0; i < K_SIZE; i++) begin
                    for (int unsigned j = 0; j + 1 < K_SIZE; j++) begin
                        win_q[i][j] <= win_q[i][j+1];
                    end
                end
                for (int unsigned i = 0; i + 1 < K_SIZE; i++) begin
                    win_q[i][K_SIZE-1] <= lb_q[i][col_q];
                end
                win_q[K_SIZE-1][K_SIZE-1] <= in_pixel;
            end
        end
    end

    // Line-buffer contents are never reset; the emit guard keeps stale data out.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i + 2 < K_SIZE; i++) begin
                lb_q[i][col_q] <= lb_q[i+1][col_q];
            end
            lb_q[K_SIZE-2][col_q] <= in_pixel;
        end
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming producer that turns a raster-scan pixel stream into K_SIZE x K_SIZE windows for the combinational convolution unit.
- Holds K_SIZE-1 line buffers plus a K_SIZE x K_SIZE window register array.
- Emits one window per valid convolution position (no padding, stride 1) over a valid/ready handshake.
- Sits between the image/feature-map source and the conv unit; pixels are opaque 16-bit FP16 words.

Parameters:
- K_SIZE, 5, kernel/window edge length; must match the downstream conv unit.
- IMG_W, 28, pixels per row; IMG_W >= K_SIZE.
- IMG_H, 28, rows per frame; IMG_H >= K_SIZE.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block accepts a pixel this cycle.
- in_pixel  input  16  FP16 pixel, row-major raster order.
- win_valid  output  1  win_out holds a valid window.
- win_ready  input  1  consumer takes the window this cycle.
- win_out  output  16 x [0:K_SIZE-1][0:K_SIZE-1]  unpacked window array, same layout as the conv unit input.
- win_last  output  1  qualifies win_valid; high on the final window of a frame.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-high. Port names are clk and rst.
- Reset values:
  - win_valid=0, win_last=0, frame_done=0.
  - Column/row counters=0; win_out registers=0.
  - Line-buffer contents are not reset.
- Reset mid-frame:
  - Discards the partial frame, including any pending window.
  - The next accepted pixel is treated as (0,0).
- Input handshake:
  - Pixel accepted when in_valid && in_ready.
  - in_ready = !win_valid || win_ready (combinational). It is 1 after reset.
- Counters:
  - col increments per accepted pixel.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1), both wrap to 0.
- On each accept at (col,row):
  - Window columns shift left by one: win[i][j] <= win[i][j+1].
  - New right column: win[i][K_SIZE-1] = line buffer i at column col for i<K_SIZE-1, and in_pixel for i=K_SIZE-1.
  - Line buffers shift: line i <= line i+1 at col; the newest line takes in_pixel.
- Orientation:
  - win_out[i][j] = pixel(row-K_SIZE+1+i, col-K_SIZE+1+j).
  - [0][0] is the top-left (oldest) pixel; [K-1][K-1] is the pixel just accepted.
- Emit condition: col >= K_SIZE-1 && row >= K_SIZE-1.
  - win_valid rises the cycle after the accept (latency 1).
  - Stale columns from the previous row are never emitted.
- Output handshake:
  - win_valid stays high and win_out stays stable until win_ready.
  - On a win_ready handshake with no new emitting accept, win_valid clears.
  - If a handshake and an emitting accept happen in the same cycle, win_valid stays 1 with the new window.
  - No window is dropped or duplicated.
- Windows per frame: (IMG_W-K_SIZE+1)*(IMG_H-K_SIZE+1); 576 at defaults.
- win_last is high together with the window for pixel (IMG_W-1, IMG_H-1).
- frame_done is asserted the cycle after that pixel is accepted, for exactly one cycle, regardless of win_ready.
- Frames run back-to-back with no idle cycle required. No state from the previous frame reaches emitted windows.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H).
- Line-buffer storage is (K_SIZE-1)*IMG_W words.

Test Plan:
- Reset mid-frame: assert rst at pixel 300, release, stream a full frame -> win_valid=0 and in_ready=1 during reset; exactly 576 windows afterwards.
- Ramp frame (pixel value = row*28+col), win_ready=1:
  - First window appears the cycle after pixel 116 is accepted.
  - That window has win[0][0]=0, win[0][4]=4, win[4][0]=112, win[4][4]=116.
  - The second window has win[0][0]=1, win[4][4]=117.
- Full-frame count, ramp stimulus:
  - 576 windows total; win_last only on the 576th, where win[4][4]=783 and win[0][0]=667.
  - One frame_done pulse.
- Backpressure: hold win_ready=0 for 10 cycles while win_valid=1 -> in_ready=0 and win_out unchanged throughout; the full sequence still matches the reference model.
- Random in_valid gaps plus random win_ready (~50%) -> window sequence bit-identical to the no-stall run.
- Two back-to-back ramp frames with different offsets (0, 1000) -> the second frame's first window is win[0][0]=1000, win[4][4]=1116; no first-frame values appear.
